// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - vertical phase enum and default 640x480@60 timing constants

package vga_pkg;

  typedef enum logic [1:0] {
    V_ACT  = 2'd0,
    V_FP   = 2'd1,
    V_SYNC = 2'd2,
    V_BP   = 2'd3
  } vstate_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_vphase_fsm.sv
// rtl/vga_vphase_fsm.sv - vertical phase FSM and line counter, advanced by the upstream TC
// Enum constants are package-scoped because the V_FP/V_SYNC parameter names shadow them.

module vga_vphase_fsm #(
  parameter int V_ACTIVE = vga_pkg::DEF_V_ACTIVE,
  parameter int V_FP     = vga_pkg::DEF_V_FP,
  parameter int V_SYNC   = vga_pkg::DEF_V_SYNC,
  parameter int V_BP     = vga_pkg::DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tc,
  output logic [9:0] line,
  output logic       in_act,
  output logic       in_sync,
  output logic       wrap
);

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] LINE_LAST = 10'(V_TOTAL - 1);

  vga_pkg::vstate_t state, state_n;
  logic [9:0] phase, phase_n, phase_last, line_n;
  logic       wrap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= vga_pkg::V_ACT;
      phase <= '0;
      line  <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      line  <= line_n;
      wrap  <= wrap_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    line_n     = line;
    wrap_n     = 1'b0;
    phase_last = 10'(V_BP - 1);

    case (state)
      vga_pkg::V_ACT:  phase_last = 10'(V_ACTIVE - 1);
      vga_pkg::V_FP:   phase_last = 10'(V_FP - 1);
      vga_pkg::V_SYNC: phase_last = 10'(V_SYNC - 1);
      default:         phase_last = 10'(V_BP - 1);
    endcase

    // Every TC is a line, even back-to-back ones.
    if (tc) begin
      if (line == LINE_LAST) begin
        line_n = '0;
        wrap_n = 1'b1;
      end else begin
        line_n = line + 10'd1;
      end

      if (phase == phase_last) begin
        phase_n = '0;
        case (state)
          vga_pkg::V_ACT:  state_n = vga_pkg::V_FP;
          vga_pkg::V_FP:   state_n = vga_pkg::V_SYNC;
          vga_pkg::V_SYNC: state_n = vga_pkg::V_BP;
          default:         state_n = vga_pkg::V_ACT;
        endcase
      end else begin
        phase_n = phase + 10'd1;
      end
    end
  end

  assign in_act  = (state == vga_pkg::V_ACT);
  assign in_sync = (state == vga_pkg::V_SYNC);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA sync/video decode registers driven by an upstream hCount/TC
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.

module vga_sync_gen #(
  parameter int H_ACTIVE = vga_pkg::DEF_H_ACTIVE,
  parameter int H_FP     = vga_pkg::DEF_H_FP,
  parameter int H_SYNC   = vga_pkg::DEF_H_SYNC,
  parameter int V_ACTIVE = vga_pkg::DEF_V_ACTIVE,
  parameter int V_FP     = vga_pkg::DEF_V_FP,
  parameter int V_SYNC   = vga_pkg::DEF_V_SYNC,
  parameter int V_BP     = vga_pkg::DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hCount,
  input  logic        TC,
  output logic        hSync,
  output logic        vSync,
  output logic        videoOn,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic [9:0]  vCount,
  output logic        frameStart
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] H_VIS    = 32'(H_ACTIVE);
  localparam logic [31:0] H_LIMIT  = 32'(vga_pkg::H_TOTAL);

  logic in_act, in_sync, wrap;
  logic h_valid, h_sync_zone, visible;

  vga_vphase_fsm #(
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_vphase (
    .clk     (clk),
    .rst     (rst),
    .tc      (TC),
    .line    (vCount),
    .in_act  (in_act),
    .in_sync (in_sync),
    .wrap    (wrap)
  );

  // Anything past the end of the line is blanking, whatever its value.
  assign h_valid     = (hCount < H_LIMIT);
  assign h_sync_zone = h_valid && (hCount >= HS_START) && (hCount < HS_END);
  assign visible     = h_valid && (hCount < H_VIS) && in_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hSync      <= 1'b1;
      vSync      <= 1'b1;
      videoOn    <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      frameStart <= 1'b0;
    end else begin
      hSync      <= ~h_sync_zone;
      vSync      <= ~in_sync;
      videoOn    <= visible;
      pixelX     <= visible ? hCount[9:0] : 10'd0;
      pixelY     <= visible ? vCount : 10'd0;
      frameStart <= wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCount <= '0;
    end else if (wrap) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized directed bench for vga_sync_gen against a line/pixel arithmetic model

module tb_vga_sync_gen;

  localparam int HA = 640, HS0 = 656, HS1 = 752, HT = 800;
  localparam int VA = 480, VS0 = 490, VS1 = 492, VT = 525;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hCount;
  logic        TC;
  logic        hSync, vSync, videoOn, frameStart;
  logic [9:0]  pixelX, pixelY, vCount;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frameCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  int m_line = 0;
  bit m_wrap = 1'b0;
  int fs_seen = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk        (clk),
    .rst        (rst),
    .hCount     (hCount),
    .TC         (TC),
    .hSync      (hSync),
    .vSync      (vSync),
    .videoOn    (videoOn),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .vCount     (vCount),
    .frameStart (frameStart)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frameCount (frameCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_hSync", hSync, 1);
    check("rst_vSync", vSync, 1);
    check("rst_videoOn", videoOn, 0);
    check("rst_pixelX", pixelX, 0);
    check("rst_pixelY", pixelY, 0);
    check("rst_vCount", vCount, 0);
    check("rst_frameStart", frameStart, 0);
`ifdef VGA_FRAME_CNT_EN
    check("rst_frameCount", frameCount, 0);
`endif
  endtask

  function automatic logic [31:0] rand_hc();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = $urandom;
      1:       v = 32'(HT + $urandom_range(0, 223));
      default: v = 32'($urandom_range(0, HT - 1));
    endcase
    return v;
  endfunction

  // One clock: drive at negedge, expect outputs one edge later from the pre-edge line.
  task automatic step(input logic [31:0] hc, input bit tc);
    bit vis, exp_h, exp_v, exp_fs;
    int exp_px, exp_py;
    hCount = hc;
    TC     = tc;
    vis    = (hc < HA) && (m_line < VA);
    exp_h  = !((hc >= HS0) && (hc < HS1));
    exp_v  = !((m_line >= VS0) && (m_line < VS1));
    exp_fs = m_wrap;
    exp_px = vis ? int'(hc % 1024) : 0;
    exp_py = vis ? m_line : 0;
    m_wrap = tc && (m_line == VT - 1);
    if (tc) m_line = (m_line + 1) % VT;
    @(posedge clk);
    @(negedge clk);
    check("hSync", hSync, exp_h);
    check("vSync", vSync, exp_v);
    check("videoOn", videoOn, vis);
    check("pixelX", pixelX, exp_px);
    check("pixelY", pixelY, exp_py);
    check("vCount", vCount, m_line);
    check("frameStart", frameStart, exp_fs);
    if (frameStart) fs_seen++;
  endtask

  task automatic goto_line(input int n);
    for (int i = 0; i < VT && m_line != n; i++) step(rand_hc(), 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    hCount = '0;
    TC     = 1'b0;
    #2;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;

    // Full frame with back-to-back TC; exactly one frameStart after the wrap.
    fs_seen = 0;
    for (int i = 0; i < VT; i++) step(rand_hc(), 1'b1);
    check("frame_wrap_vCount", vCount, 0);
    step(rand_hc(), 1'b0);
    step(rand_hc(), 1'b0);
    check("frame_pulses", fs_seen, 1);

    // hSync edges on line 10.
    goto_line(10);
    step(32'd655, 1'b0);
    check("hs_655", hSync, 1);
    step(32'd656, 1'b0);
    check("hs_656", hSync, 0);
    step(32'd751, 1'b0);
    check("hs_751", hSync, 0);
    step(32'd752, 1'b0);
    check("hs_752", hSync, 1);

    // Visible-area corner on line 479.
    goto_line(479);
    step(32'd639, 1'b0);
    check("vis_639_on", videoOn, 1);
    check("vis_639_x", pixelX, 639);
    check("vis_639_y", pixelY, 479);
    step(32'd640, 1'b0);
    check("vis_640_on", videoOn, 0);
    check("vis_640_x", pixelX, 0);
    check("vis_640_y", pixelY, 0);

    // vSync falls entering line 490, rises entering 492.
    goto_line(489);
    step(32'd0, 1'b1);
    step(32'd1, 1'b0);
    check("vs_490", vSync, 0);
    step(32'd0, 1'b1);
    step(32'd0, 1'b1);
    step(32'd1, 1'b0);
    check("vs_492", vSync, 1);

    // Random mix of hCount and sparse/consecutive TC.
    for (int i = 0; i < 1500; i++) step(rand_hc(), ($urandom_range(0, 3) == 0));

    // Mid-frame reset at line 300: TC ignored, resume from 0, no frameStart.
    goto_line(300);
    #2 rst = 1'b1;
    #1 check_reset_values();
    TC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_vCount", vCount, 0);
    end
    rst    = 1'b0;
    m_line = 0;
    m_wrap = 1'b0;
    fs_seen = 0;
    step(rand_hc(), 1'b1);
    check("post_rst_vCount", vCount, 1);
    step(rand_hc(), 1'b0);
    step(rand_hc(), 1'b0);
    check("post_rst_no_fs", fs_seen, 0);

`ifdef VGA_FRAME_CNT_EN
    goto_line(0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    m_line = 0;
    m_wrap = 1'b0;
    for (int i = 0; i < 3 * VT; i++) step(rand_hc(), 1'b1);
    step(rand_hc(), 1'b0);
    check("frameCount_3", frameCount, 3);
    force dut.frameCount = 16'hFFFF;
    @(negedge clk);
    release dut.frameCount;
    for (int i = 0; i < VT; i++) step(rand_hc(), 1'b1);
    step(rand_hc(), 1'b0);
    check("frameCount_wrap", frameCount, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-005 SHALL have parameter V_FP, default 10; parameter V_SYNC, default 2; parameter V_BP, default 33 (lines); total lines = sum = 525.
REQ-006 SHALL have port clk, input, 1, pixel clock; the design has one clock only, and all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port hCount, input, 32, horizontal position from the upstream line counter (range 0..799).
REQ-009 SHALL have port TC, input, 1, upstream line terminal count, high for the one cycle in which hCount==0.
REQ-010 SHALL have ports hSync and vSync, output, 1 each, active-low syncs.
REQ-011 SHALL have port videoOn, output, 1, high inside the visible area.
REQ-012 SHALL have ports pixelX and pixelY, output, 10 each, visible coordinates.
REQ-013 SHALL have port vCount, output, 10, current line 0..524.
REQ-014 SHALL have port frameStart, output, 1, one-cycle pulse at each frame wrap.

Function
REQ-015 vCount SHALL increment on each rising clk edge where TC==1, and wrap from 524 to 0.
REQ-016 The vertical FSM SHALL have the states V_ACT (lines 0..479), V_FP (480..489), V_SYNC (490..491) and V_BP (492..524), and it SHALL advance only on TC.
REQ-017 The FSM SHALL transition V_ACT->V_FP->V_SYNC->V_BP->V_ACT when the line count within a phase reaches that phase's length; no other transitions are legal.
REQ-018 hSync, vSync, videoOn, pixelX and pixelY SHALL be registered and lag hCount/vCount by exactly 1 clk.
REQ-019 hSync SHALL be 0 iff H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-020 vSync SHALL be 0 iff the FSM is in V_SYNC.
REQ-021 videoOn SHALL be 1 iff hCount < H_ACTIVE and the FSM is in V_ACT.
REQ-022 pixelX SHALL equal hCount[9:0] and pixelY SHALL equal vCount when videoOn would be 1; both SHALL hold 0 otherwise.
REQ-023 frameStart SHALL pulse for exactly 1 clk on the edge after vCount wraps 524->0.
REQ-024 An out-of-range hCount >= 800 SHALL be treated as blanking: videoOn=0 and hSync=1.
REQ-025 If TC is high on consecutive cycles, each cycle SHALL count as a separate line, with no error stalling.

Reset
REQ-026 rst SHALL force the following immediately, with no clock needed: vCount=0, FSM=V_ACT, hSync=1, vSync=1, videoOn=0, pixelX=0, pixelY=0, frameStart=0, frameCount=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after deassertion, counting SHALL resume from line 0 on the next TC, with no frameStart pulse.
REQ-028 TC SHALL be ignored while rst==1.

Configuration
REQ-029 With macro VGA_FRAME_CNT_EN defined, the block SHALL add output frameCount (16 bits), which increments with each frameStart and wraps from 65535 to 0.
REQ-030 Without VGA_FRAME_CNT_EN, the frameCount port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package vga_pkg SHALL hold the vertical state enum (V_ACT, V_FP, V_SYNC, V_BP) and the default 640x480@60 timing constants, including H_TOTAL=800 and V_TOTAL=525.
REQ-032 One sub-module, vga_vphase_fsm, SHALL hold the vertical FSM and vCount; the top level SHALL hold the sync/video decode registers.

Verification
REQ-033 Reset, then drive hCount 0..799 with TC at hCount==0 for 525 lines -> vCount steps 0..524->0, and frameStart pulses once.
REQ-034 Line 10, hCount 655/656/751/752 -> hSync 1/0/0/1, one clk later.
REQ-035 TC pulses carrying vCount 489->490->492 -> vSync falls on entry to line 490 and rises on entry to line 492.
REQ-036 hCount=639 on line 479 -> videoOn=1, pixelX=639, pixelY=479; hCount=640 -> videoOn=0, pixelX=0, pixelY=0.
REQ-037 Assert rst at line 300, release it, then apply one TC -> all outputs at reset values during rst, then vCount=1, with no frameStart pulse.
REQ-038 With VGA_FRAME_CNT_EN defined, run 3 frames -> frameCount=3; force the count to 65535 and run 1 more frame -> frameCount=0.
